// File: rtl/db_pkg.sv
// Shared state encoding, counter width and default timing for the button event detector.
package db_pkg;

  localparam int unsigned CNT_W             = 32;
  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned DOUBLE_WINDOW_DEF = 12_500_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_LONG    = 3'd2,
    ST_GAP     = 3'd3,
    ST_SECOND  = 3'd4
  } state_e;

endpackage

// File: rtl/db_edge_detect.sv
// Rise/fall detection against a one-cycle registered copy of the input level.
module db_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_rise_c,
  output logic o_fall_c,
  output logic o_level
);

  logic r_prev;

  // Resets low so a level already high at reset release reads as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_in;
  end

  assign o_rise_c = i_in & ~r_prev;
  assign o_fall_c = ~i_in & r_prev;
  assign o_level  = r_prev;

endmodule

// File: rtl/db_button_event.sv
// Button event classifier: press/release/single/double/long pulses from a clean level.
// Repeat pulses during a long hold exist only when DB_BUTTON_EVENT_REPEAT_EN is defined.
module db_button_event
  import db_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned DOUBLE_WINDOW = DOUBLE_WINDOW_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_signal,
  output logic o_press,
  output logic o_release,
  output logic o_single_click,
  output logic o_double_click,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(DOUBLE_WINDOW - 1);
`ifdef DB_BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_rise, w_fall;
  logic             r_press, r_release, r_single, r_double, r_long;
  logic             w_press_nxt, w_release_nxt, w_single_nxt, w_double_nxt, w_long_nxt;
`ifdef DB_BUTTON_EVENT_REPEAT_EN
  logic             r_repeat, w_repeat_nxt;
`endif

  db_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .i_in     (i_signal),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall),
    .o_level  (o_held)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // Next state, counter and pulse requests; fall beats long, rise beats timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_inc;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_single_nxt  = 1'b0;
    w_double_nxt  = 1'b0;
    w_long_nxt    = 1'b0;
`ifdef DB_BUTTON_EVENT_REPEAT_EN
    w_repeat_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
          w_press_nxt = 1'b1;
        end
      end
      ST_PRESSED, ST_SECOND: begin
        if (w_fall) begin
          w_state_nxt   = (r_state == ST_PRESSED) ? ST_GAP : ST_IDLE;
          w_release_nxt = 1'b1;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_LONG;
          w_long_nxt  = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
        end
`ifdef DB_BUTTON_EVENT_REPEAT_EN
        else if (r_cnt == REPEAT_LAST) begin
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`else
        w_cnt_nxt = '0;
`endif
      end
      ST_GAP: begin
        if (w_rise) begin
          w_state_nxt  = ST_SECOND;
          w_press_nxt  = 1'b1;
          w_double_nxt = 1'b1;
        end else if (r_cnt == WINDOW_LAST) begin
          w_state_nxt  = ST_IDLE;
          w_single_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
`ifdef DB_BUTTON_EVENT_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_single  <= w_single_nxt;
      r_double  <= w_double_nxt;
      r_long    <= w_long_nxt;
`ifdef DB_BUTTON_EVENT_REPEAT_EN
      r_repeat  <= w_repeat_nxt;
`endif
    end
  end

  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_single_click = r_single;
  assign o_double_click = r_double;
  assign o_long_press   = r_long;
`ifdef DB_BUTTON_EVENT_REPEAT_EN
  assign o_repeat       = r_repeat;
`else
  assign o_repeat       = 1'b0;
`endif

endmodule

// File: tb/tb_db_button_event.sv
// Directed bench for db_button_event with LONG=8, WINDOW=6, REPEAT=4.
module tb_db_button_event;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic o_press, o_release, o_single_click, o_double_click, o_long_press, o_repeat, o_held;
  logic [6:0] outs;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_m [7];
  logic [63:0] obs_m [7];
  string       nm    [7] = '{"press", "release", "single", "double", "long", "repeat", "held"};

  always #5 clk = ~clk;

  assign outs = {o_press, o_release, o_single_click, o_double_click, o_long_press, o_repeat, o_held};

  db_button_event #(
    .LONG_CYCLES   (8),
    .DOUBLE_WINDOW (6),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_signal       (sig),
    .o_press        (o_press),
    .o_release      (o_release),
    .o_single_click (o_single_click),
    .o_double_click (o_double_click),
    .o_long_press   (o_long_press),
    .o_repeat       (o_repeat),
    .o_held         (o_held)
  );

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Step k drives pat[k] before edge k; outputs after edge k land in bit k.
  task automatic run_pattern(input logic [63:0] pat, input int n);
    for (int j = 0; j < 7; j++) obs_m[j] = '0;
    for (int k = 0; k < n; k++) begin
      sig = pat[k];
      @(posedge clk);
      #1;
      obs_m[0][k] = o_press;
      obs_m[1][k] = o_release;
      obs_m[2][k] = o_single_click;
      obs_m[3][k] = o_double_click;
      obs_m[4][k] = o_long_press;
      obs_m[5][k] = o_repeat;
      obs_m[6][k] = o_held;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("FAIL reset/in_reset got=%b want=%b", outs, 7'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("FAIL reset/after_release got=%b want=%b", outs, 7'b0);
    end
  endtask

  task automatic test_single_click;
    logic [63:0] pat;
    pat = span(2, 4);
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[0] = span(2, 2);
    exp_m[1] = span(5, 5);
    exp_m[2] = span(11, 11);
    exp_m[6] = pat;
    run_pattern(pat, 15);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL single_click/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  task automatic test_double_click;
    logic [63:0] pat;
    pat = span(2, 4) | span(7, 9);
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[0] = span(2, 2) | span(7, 7);
    exp_m[1] = span(5, 5) | span(10, 10);
    exp_m[3] = span(7, 7);
    exp_m[6] = pat;
    run_pattern(pat, 20);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL double_click/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  task automatic test_long_press;
    logic [63:0] pat;
    pat = span(2, 22);
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[0] = span(2, 2);
    exp_m[1] = span(23, 23);
    exp_m[4] = span(10, 10);
`ifdef DB_BUTTON_EVENT_REPEAT_EN
    exp_m[5] = span(14, 14) | span(18, 18) | span(22, 22);
`endif
    exp_m[6] = pat;
    run_pattern(pat, 32);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL long_press/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  // Fall lands on the long threshold; second rise lands on the window timeout.
  task automatic test_boundaries;
    logic [63:0] pat;
    pat = span(2, 9) | span(16, 18);
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[0] = span(2, 2) | span(16, 16);
    exp_m[1] = span(10, 10) | span(19, 19);
    exp_m[3] = span(16, 16);
    exp_m[6] = pat;
    run_pattern(pat, 30);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL boundaries/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  task automatic test_second_long;
    logic [63:0] pat;
    pat = span(2, 3) | span(5, 14);
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[0] = span(2, 2) | span(5, 5);
    exp_m[1] = span(4, 4) | span(15, 15);
    exp_m[3] = span(5, 5);
    exp_m[4] = span(13, 13);
    exp_m[6] = pat;
    run_pattern(pat, 24);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL second_long/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  // Second rise one cycle after the timeout is a fresh press, not a double.
  task automatic test_back_to_back;
    logic [63:0] pat;
    pat = span(2, 3) | span(11, 12);
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[0] = span(2, 2) | span(11, 11);
    exp_m[1] = span(4, 4) | span(13, 13);
    exp_m[2] = span(10, 10) | span(19, 19);
    exp_m[6] = pat;
    run_pattern(pat, 22);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL back_to_back/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    run_pattern(span(2, 5), 6);
    total++;
    if (obs_m[0] !== span(2, 2)) begin
      bad++;
      $display("FAIL reset_mid/pre_press got=%h want=%h", obs_m[0], span(2, 2));
    end
    rst = 1'b1;
    #1;
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid/async_clear got=%b want=%b", outs, 7'b0);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (outs !== 7'b0) begin
        bad++;
        $display("FAIL reset_mid/held_in_reset got=%b want=%b", outs, 7'b0);
      end
    end
    rst = 1'b0;
    sig = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (outs !== 7'b1000001) begin
      bad++;
      $display("FAIL reset_mid/first_cycle got=%b want=%b", outs, 7'b1000001);
    end
    for (int j = 0; j < 7; j++) exp_m[j] = '0;
    exp_m[1] = span(3, 3);
    exp_m[2] = span(9, 9);
    exp_m[6] = span(0, 2);
    run_pattern(span(0, 2), 13);
    for (int j = 0; j < 7; j++) begin
      total++;
      if (obs_m[j] !== exp_m[j]) begin
        bad++;
        $display("FAIL reset_mid/%s got=%h want=%h", nm[j], obs_m[j], exp_m[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_boundaries();
    test_second_long();
    test_back_to_back();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/db_button_event.md
DB_BUTTON_EVENT -- requirements
Module: db_button_event

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50000000: hold duration, in clk cycles, that classifies a press as long.
REQ-002 SHALL have parameter DOUBLE_WINDOW, default 12500000: maximum release-to-second-press gap, in clk cycles, for a double click.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000: period of repeat pulses once a long press has fired.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 signal  input  1  debounced, clk-synchronous button level; 1 = pressed.
REQ-007 press  output  1  one-cycle pulse on each press.
REQ-008 release  output  1  one-cycle pulse on each release.
REQ-009 single_click  output  1  one-cycle pulse when a short press is not followed by a second press.
REQ-010 double_click  output  1  one-cycle pulse when a second press starts inside the window.
REQ-011 long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-012 repeat  output  1  one-cycle pulse every REPEAT_CYCLES while a long hold continues (macro-gated).
REQ-013 held  output  1  registered copy of signal.

Function
REQ-014 SHALL drive all outputs from registers; every pulse is 1 cycle wide and appears 1 cycle after the clk edge where the triggering condition is sampled.
REQ-015 SHALL detect edges by comparing signal against a 1-cycle registered copy (prev); rise = signal & ~prev, fall = ~signal & prev.
REQ-016 SHALL implement FSM states IDLE, PRESSED, LONG, GAP, SECOND, with one 32-bit counter cleared on every state change.
REQ-017 IDLE: on rise -> PRESSED, press pulse.
REQ-018 PRESSED: counter increments each cycle; on fall -> GAP, release pulse; when counter == LONG_CYCLES-1 with signal high -> LONG, long_press pulse.
REQ-019 LONG: counter increments and wraps to 0 at REPEAT_CYCLES-1, issuing a repeat pulse at each wrap; on fall -> IDLE, release pulse; no single_click follows.
REQ-020 GAP: counter increments; on rise before counter reaches DOUBLE_WINDOW-1 -> SECOND, press and double_click pulses in the same cycle; at counter == DOUBLE_WINDOW-1 with no rise -> IDLE, single_click pulse.
REQ-021 SECOND: on fall -> IDLE, release pulse; long detection applies as in PRESSED (-> LONG) so that a held second press can still long-press.
REQ-022 Rise and window timeout in the same cycle: the rise wins (double_click, no single_click).
REQ-023 Fall and long threshold in the same cycle: the fall wins (release, no long_press).
REQ-024 Counter SHALL saturate rather than wrap in PRESSED, GAP, and SECOND.
REQ-025 Parameters SHALL be >= 2; behaviour for smaller values is undefined.

Reset
REQ-026 On rst: state IDLE, counter 0, prev 0, held 0, all pulse outputs 0, asynchronously.
REQ-027 Deassertion with signal already high SHALL produce a press pulse on the first cycle (prev resets to 0).
REQ-028 Reset mid-press SHALL abandon the event silently: no release, single_click, or long_press.

Configuration
REQ-029 Macro DB_BUTTON_EVENT_REPEAT_EN defined: repeat behaves per REQ-019.
REQ-030 Macro absent: repeat tied to 0, no repeat wrap logic; LONG holds without counting until fall; all other behaviour unchanged.

Structure
REQ-031 Shared package db_pkg SHALL hold the FSM state enum, the counter width constant (32), and the default parameter values.
REQ-032 Edge detection SHALL be a sub-module db_edge_detect (clk, rst, in -> rise, fall, level).

Verification (LONG_CYCLES=8, DOUBLE_WINDOW=6, REPEAT_CYCLES=4, macro defined)
REQ-033 Press held 3 cycles, then released for 10 -> press, release, then single_click 6 cycles after release; no double_click or long_press.
REQ-034 Press 3, release 2, press 3, release -> press, double_click+press together, then release; no single_click.
REQ-035 Hold 20 cycles -> long_press 8 cycles after press, repeat every 4 cycles after that (3 pulses), then release; no single_click.
REQ-036 Fall exactly on the long-threshold cycle -> release only; second press exactly on the window-timeout cycle -> double_click only.
REQ-037 rst asserted mid-hold, then released with signal high -> all outputs 0 during reset, press pulse on the first cycle after reset, no release.
REQ-038 Rebuild without the macro and rerun REQ-035 -> long_press present, repeat stays 0.
